// File: rtl/fft_stage_controller_if.sv
// rtl/fft_stage_controller_if.sv - handshake and strobe bundle of the FFT stage sequencer
interface fft_stage_controller_if;
    logic       start;
    logic       in_valid;
    logic       ob_done;
    logic       busy;
    logic       in_ready;
    logic [3:0] stage;
    logic [4:0] beat;
    logic       rd_en;
    logic       wr_en;
    logic [4:0] wr_beat;
    logic [6:0] tw_base;
    logic       ob_load;
    logic       done;

    modport master (
        output start, in_valid, ob_done,
        input  busy, in_ready, stage, beat, rd_en, wr_en, wr_beat, tw_base, ob_load, done
    );

    modport slave (
        input  start, in_valid, ob_done,
        output busy, in_ready, stage, beat, rd_en, wr_en, wr_beat, tw_base, ob_load, done
    );
endinterface

// File: rtl/fft_stage_controller.sv
// rtl/fft_stage_controller.sv - LOAD / 8 butterfly stages / UNLOAD sequencer for the 256-point FFT
module fft_stage_controller #(
    parameter int N_POINTS  = 256,
    parameter int LOG2N     = 8,
    parameter int LANES     = 8,
    parameter int STAGE_LAT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    fft_stage_controller_if.slave  bus
);
    localparam logic [4:0] LAST_BEAT  = 5'(N_POINTS / LANES - 1);
    localparam logic [3:0] LAST_STAGE = 4'(LOG2N - 1);
    localparam int         HALF_LANES = LANES / 2;
    localparam int         DC_W       = $clog2(STAGE_LAT + 1);
    localparam logic [DC_W-1:0] LAST_DRAIN = DC_W'(STAGE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD, S_DONE
    } state_t;

    state_t                state;
    logic                  busy_q;
    logic                  in_ready_q;
    logic                  rd_en_q;
    logic                  done_q;
    logic [3:0]            stage_q;
    logic [4:0]            beat_q;
    logic [DC_W-1:0]       drain_cnt;
    logic [STAGE_LAT-1:0]  wr_pipe;
    logic [4:0]            beat_pipe [STAGE_LAT];

    // Frame sequencer: one state per cycle, all strobes registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            stage_q    <= '0;
            beat_q     <= '0;
            drain_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_LOAD;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (beat_q == LAST_BEAT) begin
                            state      <= S_COMPUTE;
                            in_ready_q <= 1'b0;
                            rd_en_q    <= 1'b1;
                            stage_q    <= '0;
                            beat_q     <= '0;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (beat_q == LAST_BEAT) begin
                        state     <= S_DRAIN;
                        rd_en_q   <= 1'b0;
                        drain_cnt <= '0;
                        beat_q    <= '0;
                    end else begin
                        beat_q <= beat_q + 5'd1;
                    end
                end
                S_DRAIN: begin
                    // Stage only advances after the last in-place write of this stage has landed
                    if (drain_cnt == LAST_DRAIN) begin
                        if (stage_q == LAST_STAGE) begin
                            state   <= S_UNLOAD;
                            stage_q <= '0;
                        end else begin
                            state   <= S_COMPUTE;
                            stage_q <= stage_q + 4'd1;
                            beat_q  <= '0;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (bus.ob_done) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        state      <= S_LOAD;
                        in_ready_q <= 1'b1;
                        beat_q     <= '0;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-side delay line: read strobe and beat re-emerge STAGE_LAT cycles later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pipe <= '0;
            for (int i = 0; i < STAGE_LAT; i++) beat_pipe[i] <= '0;
        end else begin
            wr_pipe[0]   <= rd_en_q;
            beat_pipe[0] <= beat_q;
            for (int i = 1; i < STAGE_LAT; i++) begin
                wr_pipe[i]   <= wr_pipe[i-1];
                beat_pipe[i] <= beat_pipe[i-1];
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.in_ready = in_ready_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.done     = done_q;
    assign bus.stage    = stage_q;
    assign bus.beat     = beat_q;
    assign bus.wr_en    = wr_pipe[STAGE_LAT-1];
    assign bus.wr_beat  = beat_pipe[STAGE_LAT-1];
    // Stage is held through the drain, so the delayed write needs no stage copy
    assign bus.ob_load  = wr_pipe[STAGE_LAT-1] & (stage_q == LAST_STAGE);
    // Butterfly index j = beat*LANES/2, shifted at 11 bits, kept modulo N_POINTS/2
    assign bus.tw_base  = 7'((11'(beat_q) * 11'(HALF_LANES)) << stage_q);
endmodule

// File: tb/tb_fft_stage_controller.sv
// tb/tb_fft_stage_controller.sv - directed self-checking bench for fft_stage_controller
module tb_fft_stage_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fft_stage_controller_if bus();

    fft_stage_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int       cyc = 0;
    int       cnt_ready, cnt_rd, cnt_wr, cnt_obl, cnt_bursts;
    int       obl_err, trail_err, gap_err, low_run, obl_next;
    int       first_rd_cyc, last_obl_cyc;
    logic [2:0] rd_hist;
    logic     prev_rd;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        cnt_ready = 0; cnt_rd = 0; cnt_wr = 0; cnt_obl = 0; cnt_bursts = 0;
        obl_err = 0; trail_err = 0; gap_err = 0; low_run = 0; obl_next = 0;
        first_rd_cyc = 0; last_obl_cyc = 0; rd_hist = 3'b000; prev_rd = 1'b0;
    endtask

    // Observe strobes mid-cycle and accumulate per-frame statistics
    always @(negedge clk) begin
        cyc++;
        if (bus.in_ready) cnt_ready++;
        if (bus.rd_en) begin
            cnt_rd++;
            if (!prev_rd) begin
                if (cnt_bursts == 0) first_rd_cyc = cyc;
                else if (low_run != 3) gap_err++;
                cnt_bursts++;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        if (bus.wr_en !== rd_hist[2]) trail_err++;
        rd_hist = {rd_hist[1:0], bus.rd_en};
        if (bus.wr_en) cnt_wr++;
        if (bus.ob_load) begin
            cnt_obl++;
            if (int'(bus.wr_beat) != obl_next || bus.stage != 4'd7) obl_err++;
            obl_next++;
            last_obl_cyc = cyc;
        end
        prev_rd = bus.rd_en;
    end

    task automatic do_reset;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.ob_done = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_sb(input int s, input int b, input string tag);
        int n = 0;
        while (!(bus.rd_en && int'(bus.stage) == s && int'(bus.beat) == b) && n < 600) begin
            tick;
            n++;
        end
        check({tag, "_timeout"}, int'(n >= 600), 0);
    endtask

    // Wait for the last ob_load, sit in UNLOAD 10 cycles, then pulse ob_done; ends in DONE
    task automatic finish_frame(input string tag);
        int n = 0;
        while (cnt_obl < 32 && n < 600) begin
            tick;
            n++;
        end
        check({tag, "_obl_timeout"}, int'(n >= 600), 0);
        check({tag, "_unload_stage"}, int'(bus.stage), 0);
        check({tag, "_unload_busy"}, int'(bus.busy), 1);
        repeat (10) tick;
        check({tag, "_done_early"}, int'(bus.done), 0);
        bus.ob_done = 1'b1;
        tick;
        bus.ob_done = 1'b0;
        check({tag, "_done"}, int'(bus.done), 1);
    endtask

    task automatic frame_stats(input string tag, input int ready_exp);
        check({tag, "_ready_cycles"}, cnt_ready, ready_exp);
        check({tag, "_rd_count"}, cnt_rd, 256);
        check({tag, "_wr_count"}, cnt_wr, 256);
        check({tag, "_bursts"}, cnt_bursts, 8);
        check({tag, "_gaps"}, gap_err, 0);
        check({tag, "_wr_trail"}, trail_err, 0);
        check({tag, "_obl_count"}, cnt_obl, 32);
        check({tag, "_obl_beats"}, obl_err, 0);
        check({tag, "_span"}, last_obl_cyc - first_rd_cyc, 279);
    endtask

    task automatic run_full_frame(input string tag);
        clear_mon;
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check({tag, "_load_ready"}, int'(bus.in_ready), 1);
        check({tag, "_load_beat"}, int'(bus.beat), 0);
        finish_frame(tag);
        tick;
        check({tag, "_idle_done"}, int'(bus.done), 0);
        check({tag, "_idle_busy"}, int'(bus.busy), 0);
        frame_stats(tag, 32);
    endtask

    initial begin
        clear_mon;
        do_reset;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ready", int'(bus.in_ready), 0);
        check("rst_stage", int'(bus.stage), 0);
        check("rst_beat", int'(bus.beat), 0);
        check("rst_wr", int'(bus.wr_en), 0);
        check("rst_obl", int'(bus.ob_load), 0);
        check("rst_tw", int'(bus.tw_base), 0);
        check("rst_done", int'(bus.done), 0);

        // Mid-cycle reset during LOAD clears outputs immediately
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        check("pre_rst_beat", int'(bus.beat), 3);
        #2 reset = 1'b1;
        #1;
        check("async_busy", int'(bus.busy), 0);
        check("async_ready", int'(bus.in_ready), 0);
        check("async_beat", int'(bus.beat), 0);
        tick;
        reset = 1'b0;
        tick;
        check("post_rst_busy", int'(bus.busy), 0);

        run_full_frame("frame");

        // LOAD stall plus ob_done pulse inside LOAD
        clear_mon;
        bus.in_valid = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.ob_done = 1'b1;
        tick;
        bus.ob_done = 1'b0;
        check("obdone_in_load_ready", int'(bus.in_ready), 1);
        check("obdone_in_load_beat", int'(bus.beat), 1);
        repeat (11) tick;
        check("stall_beat_at", int'(bus.beat), 12);
        bus.in_valid = 1'b0;
        repeat (5) tick;
        check("stall_beat_hold", int'(bus.beat), 12);
        check("stall_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        begin
            int n = 17;
            while (!bus.rd_en && n < 100) begin
                tick;
                n++;
            end
            check("stall_compute_entry", n, 37);
        end
        check("stall_ready_cycles", cnt_ready, 37);
        finish_frame("stall");
        tick;
        check("stall_idle_busy", int'(bus.busy), 0);

        // Twiddle bases, start ignored in COMPUTE, start held in DONE
        clear_mon;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_sb(0, 31, "tw_s0b31");
        check("tw_s0b31", int'(bus.tw_base), 124);
        wait_sb(2, 5, "tw_s2b5");
        check("tw_s2b5", int'(bus.tw_base), 80);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("start_in_compute_beat", int'(bus.beat), 6);
        check("start_in_compute_rd", int'(bus.rd_en), 1);
        check("start_in_compute_stage", int'(bus.stage), 2);
        wait_sb(7, 1, "tw_s7b1");
        check("tw_s7b1", int'(bus.tw_base), 0);
        finish_frame("b2b");
        frame_stats("b2b", 32);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("b2b_load_ready", int'(bus.in_ready), 1);
        check("b2b_load_beat", int'(bus.beat), 0);
        check("b2b_load_busy", int'(bus.busy), 1);
        check("b2b_load_done", int'(bus.done), 0);

        // Abort at stage 4 beat 10, then a clean frame
        wait_sb(4, 10, "abort_pt");
        #2 reset = 1'b1;
        #1;
        check("abort_wr", int'(bus.wr_en), 0);
        check("abort_rd", int'(bus.rd_en), 0);
        check("abort_busy", int'(bus.busy), 0);
        tick;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        clear_mon;
        repeat (50) tick;
        check("abort_no_wr", cnt_wr, 0);
        check("abort_idle", int'(bus.busy), 0);
        run_full_frame("clean");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
